// File: rtl/dma_mem_responder_if.sv
// Read/write request bus between the DMA controller (master) and the
// memory-side responder (slave).
interface dma_mem_responder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
);
  logic                  dma_read_req;
  logic [ADDR_WIDTH-1:0] dma_read_addr;
  logic [DATA_WIDTH-1:0] dma_read_data;
  logic                  dma_read_valid;
  logic                  dma_write_req;
  logic [ADDR_WIDTH-1:0] dma_write_addr;
  logic [DATA_WIDTH-1:0] dma_write_data;
  logic                  dma_write_ack;

  modport master (
    output dma_read_req, dma_read_addr, dma_write_req, dma_write_addr, dma_write_data,
    input  dma_read_data, dma_read_valid, dma_write_ack
  );

  modport slave (
    input  dma_read_req, dma_read_addr, dma_write_req, dma_write_addr, dma_write_data,
    output dma_read_data, dma_read_valid, dma_write_ack
  );
endinterface

// File: rtl/dma_mem_responder.sv
// Single-port word array answering level-held DMA read/write requests after
// fixed latencies, with a preload port, sticky error flags and traffic counters.
module dma_mem_responder #(
  parameter int                    DATA_WIDTH    = 16,
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DEPTH_WORDS   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                    READ_LATENCY  = 2,
  parameter int                    WRITE_LATENCY = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  dma_mem_responder_if.slave             bus,
  input  logic                           init_we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] init_idx_i,
  input  logic [DATA_WIDTH-1:0]          init_data_i,
  output logic                           err_range_o,
  output logic                           err_align_o,
  output logic [31:0]                    rd_count_o,
  output logic [31:0]                    wr_count_o
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFB  = $clog2(BYTES);
  localparam int IW    = $clog2(DEPTH_WORDS);
  localparam int RCW   = $clog2(READ_LATENCY + 1);
  localparam int WCW   = $clog2(WRITE_LATENCY + 1);
  localparam logic [ADDR_WIDTH:0]   SPAN = (ADDR_WIDTH+1)'(DEPTH_WORDS) * (ADDR_WIDTH+1)'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] MASK = ADDR_WIDTH'(BYTES - 1);

  typedef enum logic {RD_IDLE, RD_WAIT} rd_state_e;
  typedef enum logic {WR_IDLE, WR_WAIT} wr_state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  rd_state_e             rd_state_q, rd_state_d;
  wr_state_e             wr_state_q, wr_state_d;
  logic [RCW-1:0]        rcnt_q, rcnt_d;
  logic [WCW-1:0]        wcnt_q, wcnt_d;
  logic                  rvld_q, rvld_d, ack_q, ack_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rbuf_q, rbuf_d;
  logic [31:0]           rd_count_q, rd_count_d, wr_count_q, wr_count_d;
  logic                  err_range_q, err_range_d, err_align_q, err_align_d;
  logic                  rd_acc, wr_acc;

  // Offsets wrap below BASE_ADDR, so one unsigned compare covers both bounds.
  logic [ADDR_WIDTH-1:0] rd_off, wr_off;
  logic                  rd_inr, wr_inr, rd_mis, wr_mis;
  logic [IW-1:0]         rd_idx, wr_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  assign rd_off  = bus.dma_read_addr - BASE_ADDR;
  assign wr_off  = bus.dma_write_addr - BASE_ADDR;
  assign rd_inr  = {1'b0, rd_off} < SPAN;
  assign wr_inr  = {1'b0, wr_off} < SPAN;
  assign rd_mis  = |(rd_off & MASK);
  assign wr_mis  = |(wr_off & MASK);
  assign rd_idx  = IW'(rd_off >> OFFB);
  assign wr_idx  = IW'(wr_off >> OFFB);
  assign rd_word = rd_inr ? mem[rd_idx] : '0;

  always_comb begin
    wr_state_d  = wr_state_q;
    wcnt_d      = wcnt_q;
    ack_d       = 1'b0;
    rd_state_d  = rd_state_q;
    rcnt_d      = rcnt_q;
    rvld_d      = 1'b0;
    rdata_d     = rdata_q;
    rbuf_d      = rbuf_q;
    wr_acc      = 1'b0;
    rd_acc      = 1'b0;

    unique case (wr_state_q)
      WR_IDLE: if (bus.dma_write_req && !ack_q && !init_we_i) begin
        wr_acc = 1'b1;
        if (WRITE_LATENCY == 1) ack_d = 1'b1;
        else begin
          wr_state_d = WR_WAIT;
          wcnt_d     = WCW'(WRITE_LATENCY - 1);
        end
      end
      WR_WAIT: if (wcnt_q == WCW'(1)) begin
        ack_d      = 1'b1;
        wr_state_d = WR_IDLE;
      end else wcnt_d = wcnt_q - WCW'(1);
      default: wr_state_d = WR_IDLE;
    endcase

    // The array port goes to preload, then write, then read.
    unique case (rd_state_q)
      RD_IDLE: if (bus.dma_read_req && !rvld_q && !init_we_i && !wr_acc) begin
        rd_acc = 1'b1;
        rbuf_d = rd_word;
        if (READ_LATENCY == 1) begin
          rvld_d  = 1'b1;
          rdata_d = rd_word;
        end else begin
          rd_state_d = RD_WAIT;
          rcnt_d     = RCW'(READ_LATENCY - 1);
        end
      end
      RD_WAIT: if (rcnt_q == RCW'(1)) begin
        rvld_d     = 1'b1;
        rdata_d    = rbuf_q;
        rd_state_d = RD_IDLE;
      end else rcnt_d = rcnt_q - RCW'(1);
      default: rd_state_d = RD_IDLE;
    endcase

    wr_count_d  = ack_d  ? wr_count_q + 32'd1 : wr_count_q;
    rd_count_d  = rvld_d ? rd_count_q + 32'd1 : rd_count_q;
    err_range_d = err_range_q | (wr_acc & ~wr_inr) | (rd_acc & ~rd_inr);
    err_align_d = err_align_q | (wr_acc & wr_mis) | (rd_acc & rd_mis);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state_q  <= RD_IDLE;
      wr_state_q  <= WR_IDLE;
      rcnt_q      <= '0;
      wcnt_q      <= '0;
      rvld_q      <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      rbuf_q      <= '0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      err_range_q <= 1'b0;
      err_align_q <= 1'b0;
    end else begin
      rd_state_q  <= rd_state_d;
      wr_state_q  <= wr_state_d;
      rcnt_q      <= rcnt_d;
      wcnt_q      <= wcnt_d;
      rvld_q      <= rvld_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      rbuf_q      <= rbuf_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      err_range_q <= err_range_d;
      err_align_q <= err_align_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (init_we_i) mem[init_idx_i] <= init_data_i;
    else if (wr_acc && wr_inr && !rst_i) mem[wr_idx] <= bus.dma_write_data;
  end

  assign bus.dma_read_data  = rdata_q;
  assign bus.dma_read_valid = rvld_q;
  assign bus.dma_write_ack  = ack_q;
  assign err_range_o        = err_range_q;
  assign err_align_o        = err_align_q;
  assign rd_count_o         = rd_count_q;
  assign wr_count_o         = wr_count_q;
endmodule
